// File: rtl/turn_queue_control_if.sv
// turn_queue_control_if: button/step/restart inputs and direction/queue-status outputs of turn_queue_control
interface turn_queue_control_if #(
  parameter int PLAYERS = 1,
  parameter int DEPTH   = 2
);
  localparam int LW = $clog2(DEPTH + 1);
  logic [4*PLAYERS-1:0]  i_buttons;
  logic                  i_step;
  logic                  i_restart;
  logic [2*PLAYERS-1:0]  o_dir;
  logic [PLAYERS-1:0]    o_turned;
  logic [PLAYERS*LW-1:0] o_level;
  modport master (output i_buttons, i_step, i_restart, input o_dir, o_turned, o_level);
  modport slave  (input i_buttons, i_step, i_restart, output o_dir, o_turned, o_level);
endinterface

// File: rtl/turn_queue_control.sv
// turn_queue_control: per-player button debounce, perpendicular-turn FIFO and registered direction output
module turn_queue_control #(
  parameter int         PLAYERS      = 1,
  parameter int         DEPTH        = 2,
  parameter int         DEBOUNCE_LEN = 8,
  parameter logic [1:0] INIT_DIR     = 2'b11
) (
  input logic                 clk,
  input logic                 rst_n,
  turn_queue_control_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = DEBOUNCE_LEN > 1 ? $clog2(DEBOUNCE_LEN) : 1;
  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0]    s1_q, s2_q, deb_q, prev_q, press;
    logic [CW-1:0] cnt_q [4];
    logic [1:0]    fifo_q [DEPTH];
    logic [1:0]    fifo_d [DEPTH];
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    dir_q, dir_d, cand, ref_dir;
    logic          turned_q, turned_d, valid;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q   <= '0;
        s2_q   <= '0;
        deb_q  <= '0;
        prev_q <= '0;
        for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
      end else begin
        s1_q   <= bus.i_buttons[4*p +: 4];
        s2_q   <= s1_q;
        prev_q <= deb_q;
        for (int b = 0; b < 4; b++) begin
          if (s2_q[b] == deb_q[b]) cnt_q[b] <= '0;
          else if (cnt_q[b] == CW'(DEBOUNCE_LEN - 1)) begin
            deb_q[b] <= s2_q[b];
            cnt_q[b] <= '0;
          end else cnt_q[b] <= cnt_q[b] + CW'(1);
        end
      end
    end
    assign press = deb_q & ~prev_q;
    // a new turn is validated against the newest queued direction, not the one currently applied
    always_comb begin
      cand    = press[0] ? 2'b00 : press[1] ? 2'b01 : press[2] ? 2'b10 : 2'b11;
      ref_dir = dir_q;
      for (int i = 0; i < DEPTH; i++) if (LW'(i + 1) == level_q) ref_dir = fifo_q[i];
      valid    = |press && (cand[1] != ref_dir[1]);
      fifo_d   = fifo_q;
      level_d  = level_q;
      dir_d    = dir_q;
      turned_d = 1'b0;
      if (bus.i_restart) begin
        level_d = '0;
        dir_d   = INIT_DIR;
      end else begin
        if (bus.i_step && level_q != '0) begin
          dir_d    = fifo_q[0];
          turned_d = 1'b1;
          for (int i = 0; i < DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
          level_d  = level_q - LW'(1);
        end
        if (valid && bus.i_step && level_q == '0) begin
          dir_d    = cand;
          turned_d = 1'b1;
        end else if (valid && level_d != LW'(DEPTH)) begin
          for (int i = 0; i < DEPTH; i++) if (LW'(i) == level_d) fifo_d[i] = cand;
          level_d = level_d + LW'(1);
        end
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        level_q  <= '0;
        dir_q    <= INIT_DIR;
        turned_q <= 1'b0;
      end else begin
        fifo_q   <= fifo_d;
        level_q  <= level_d;
        dir_q    <= dir_d;
        turned_q <= turned_d;
      end
    end
    assign bus.o_dir[2*p +: 2]    = dir_q;
    assign bus.o_turned[p]        = turned_q;
    assign bus.o_level[LW*p +: LW] = level_q;
  end
endmodule
